counter_mod_cmp: RTL and testbench



---
 rtl/counter_mod_cmp_if.sv | 40 ++++
 rtl/counter_mod_cmp.sv | 115 +++++++++++
 tb/tb_counter_mod_cmp.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/counter_mod_cmp_if.sv
// Control/status bundle for counter_mod_cmp.
// COUNTER_MOD_CMP_CAPTURE_EN adds the cap/cap_q capture pair.
interface counter_mod_cmp_if #(
  parameter int unsigned WIDTH = 8
);
  logic             ena;
  logic             sel;
  logic             sload;
  logic [WIDTH-1:0] d_load;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] top;
  logic [1:0]       mode;
  logic [WIDTH-1:0] cmp;
  logic [WIDTH-1:0] q;
  logic             carry_out;
  logic             cmp_match;
  logic             done;
`ifdef COUNTER_MOD_CMP_CAPTURE_EN
  logic             cap;
  logic [WIDTH-1:0] cap_q;

  modport master (
    output ena, sel, sload, d_load, step, top, mode, cmp, cap,
    input  q, carry_out, cmp_match, done, cap_q
  );
  modport slave (
    input  ena, sel, sload, d_load, step, top, mode, cmp, cap,
    output q, carry_out, cmp_match, done, cap_q
  );
`else
  modport master (
    output ena, sel, sload, d_load, step, top, mode, cmp,
    input  q, carry_out, cmp_match, done
  );
  modport slave (
    input  ena, sel, sload, d_load, step, top, mode, cmp,
    output q, carry_out, cmp_match, done
  );
`endif
endinterface

// File: rtl/counter_mod_cmp.sv
// Up/down counter with step, terminal value, free/modulo/saturate/one-shot modes,
// registered carry and compare pulses. COUNTER_MOD_CMP_CAPTURE_EN adds a capture register.
module counter_mod_cmp #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic              clk,
  input logic              srst,
  counter_mod_cmp_if.slave bus
);
  typedef enum logic [1:0] {
    MODE_FREE    = 2'b00,
    MODE_MOD     = 2'b01,
    MODE_SAT     = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_t;

  mode_t            md;
  logic [WIDTH-1:0] q_r, q_nx, lim;
  logic             carry_r, carry_nx;
  logic             match_r, match_nx;
  logic             done_r, done_nx;
  logic [WIDTH:0]   sum, dif, topx, wrap;

  assign md   = mode_t'(bus.mode);
  assign sum  = {1'b0, q_r} + {1'b0, bus.step};
  assign dif  = {1'b0, q_r} - {1'b0, bus.step};
  assign topx = {1'b0, bus.top} + 1'b1;

  always_comb begin
    q_nx     = q_r;
    carry_nx = 1'b0;
    match_nx = 1'b0;
    done_nx  = done_r;
    lim      = '0;
    wrap     = '0;
    if (bus.sload) begin
      q_nx     = (md == MODE_FREE || bus.d_load <= bus.top) ? bus.d_load : bus.top;
      done_nx  = 1'b0;
      match_nx = (q_nx == bus.cmp);
    end else if (bus.ena && !(md == MODE_ONESHOT && done_r) && bus.step != '0) begin
      unique case (md)
        MODE_FREE: begin
          q_nx     = bus.sel ? dif[WIDTH-1:0] : sum[WIDTH-1:0];
          carry_nx = bus.sel ? dif[WIDTH] : sum[WIDTH];
          match_nx = (q_nx == bus.cmp);
        end
        MODE_MOD: begin
          if (!bus.sel) begin
            wrap = sum - topx;
            if (sum > {1'b0, bus.top}) begin
              q_nx     = wrap[WIDTH-1:0];
              carry_nx = 1'b1;
            end else begin
              q_nx = sum[WIDTH-1:0];
            end
          end else begin
            wrap = {1'b0, q_r} + topx - {1'b0, bus.step};
            if (q_r < bus.step) begin
              q_nx     = wrap[WIDTH-1:0];
              carry_nx = 1'b1;
            end else begin
              q_nx = dif[WIDTH-1:0];
            end
          end
          match_nx = (q_nx == bus.cmp);
        end
        default: begin
          // Saturating modes: a count that cannot move q is a hold, so no pulses.
          lim = bus.sel ? '0 : bus.top;
          if (!bus.sel)
            q_nx = (sum >= {1'b0, bus.top}) ? bus.top : sum[WIDTH-1:0];
          else
            q_nx = (q_r <= bus.step) ? '0 : dif[WIDTH-1:0];
          carry_nx = (q_nx != q_r) && (q_nx == lim);
          match_nx = (q_nx != q_r) && (q_nx == bus.cmp);
          if (md == MODE_ONESHOT && q_nx == lim)
            done_nx = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      q_r     <= RST_VAL;
      carry_r <= 1'b0;
      match_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      q_r     <= q_nx;
      carry_r <= carry_nx;
      match_r <= match_nx;
      done_r  <= done_nx;
    end
  end

  assign bus.q         = q_r;
  assign bus.carry_out = carry_r;
  assign bus.cmp_match = match_r;
  assign bus.done      = done_r;

`ifdef COUNTER_MOD_CMP_CAPTURE_EN
  logic [WIDTH-1:0] cap_r;

  always_ff @(posedge clk) begin
    if (srst)
      cap_r <= '0;
    else if (bus.cap)
      cap_r <= q_r;
  end

  assign bus.cap_q = cap_r;
`endif
endmodule

// File: tb/tb_counter_mod_cmp.sv
// Self-checking bench for counter_mod_cmp: directed scenarios plus randomized
// segments against an integer reference model. Honours COUNTER_MOD_CMP_CAPTURE_EN.
module tb_counter_mod_cmp;
  localparam int unsigned W  = 8;
  localparam int          M  = 256;
  localparam int          RV = 5;

  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  counter_mod_cmp_if #(.WIDTH(W)) bus ();
  counter_mod_cmp #(.WIDTH(W), .RST_VAL(8'd5)) dut (.clk(clk), .srst(srst), .bus(bus));

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  int exp_q, exp_c, exp_m, exp_d, exp_cap;
  int n_q, n_c, n_m, n_d, n_cap;

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, got, want, $time);
    end
  endtask

  // Next outputs from the behavioural rules, using plain integer arithmetic.
  task automatic model_next();
    int q, st, tp, md, lim;
    q = exp_q; st = int'(bus.step); tp = int'(bus.top); md = int'(bus.mode);
    n_q = q; n_c = 0; n_m = 0; n_d = exp_d; n_cap = exp_cap;
`ifdef COUNTER_MOD_CMP_CAPTURE_EN
    if (bus.cap) n_cap = exp_q;
`endif
    if (srst) begin
      n_q = RV; n_d = 0; n_cap = 0;
    end else if (bus.sload) begin
      n_q = int'(bus.d_load);
      if (md != 0 && n_q > tp) n_q = tp;
      n_d = 0;
      n_m = (n_q == int'(bus.cmp));
    end else if (bus.ena && !(md == 3 && exp_d != 0) && st != 0) begin
      if (md == 0) begin
        if (!bus.sel) begin n_c = (q + st >= M); n_q = (q + st) % M; end
        else          begin n_c = (q < st);      n_q = (q - st + M) % M; end
        n_m = (n_q == int'(bus.cmp));
      end else if (md == 1) begin
        if (!bus.sel) begin
          n_q = q + st;
          if (n_q > tp) begin n_q = n_q - (tp + 1); n_c = 1; end
        end else begin
          if (q < st) begin n_q = q + tp + 1 - st; n_c = 1; end
          else n_q = q - st;
        end
        n_m = (n_q == int'(bus.cmp));
      end else begin
        lim = bus.sel ? 0 : tp;
        if (!bus.sel) n_q = (q + st > tp) ? tp : q + st;
        else          n_q = (q < st) ? 0 : q - st;
        n_c = (n_q == lim) && (q != lim);
        n_m = (n_q != q) && (n_q == int'(bus.cmp));
        if (md == 3 && n_q == lim) n_d = 1;
      end
    end
  endtask

  task automatic tick();
    model_next();
    @(posedge clk);
    #1;
    exp_q = n_q; exp_c = n_c; exp_m = n_m; exp_d = n_d; exp_cap = n_cap;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("q", int'(bus.q), exp_q);
      chk("carry_out", int'(bus.carry_out), exp_c);
      chk("cmp_match", int'(bus.cmp_match), exp_m);
      chk("done", int'(bus.done), exp_d);
`ifdef COUNTER_MOD_CMP_CAPTURE_EN
      chk("cap_q", int'(bus.cap_q), exp_cap);
`endif
    end
  end

  task automatic load(input int v);
    bus.sload = 1'b1; bus.d_load = W'(v); tick(); bus.sload = 1'b0;
  endtask

  task automatic tick_q(input string nm, input int q, input int c);
    tick();
    chk({nm, "_q"}, int'(bus.q), q);
    chk({nm, "_c"}, int'(bus.carry_out), c);
  endtask

  initial begin
    int tp, cnt;
    exp_q = 0; exp_c = 0; exp_m = 0; exp_d = 0; exp_cap = 0;
    srst = 1'b1; bus.ena = 1'b1; bus.sel = 1'b0; bus.sload = 1'b0; bus.d_load = '0;
    bus.step = 8'd1; bus.top = 8'd255; bus.mode = 2'b00; bus.cmp = 8'd200;
`ifdef COUNTER_MOD_CMP_CAPTURE_EN
    bus.cap = 1'b0;
`endif
    tick(); tick();
    chk_en = 1'b1;
    chk("rst_q", int'(bus.q), 5);
    chk("rst_done", int'(bus.done), 0);
    srst = 1'b0;

    // free-run wrap and borrow
    bus.ena = 1'b0; load(254); chk("f_load", int'(bus.q), 254);
    bus.ena = 1'b1;
    tick_q("f0", 255, 0); tick_q("f1", 0, 1); tick_q("f2", 1, 0);
    bus.sel = 1'b1; bus.step = 8'd2; tick_q("f3", 255, 1);

    // modulo 10, step 3
    bus.mode = 2'b01; bus.top = 8'd9; bus.step = 8'd3; bus.sel = 1'b0; bus.cmp = 8'd6;
    load(0); chk("m_load", int'(bus.q), 0);
    tick_q("m0", 3, 0);
    tick_q("m1", 6, 0); chk("m1_match", int'(bus.cmp_match), 1);
    tick_q("m2", 9, 0); tick_q("m3", 2, 1); tick_q("m4", 5, 0);
    load(1); bus.sel = 1'b1; tick_q("m5", 8, 1);
    load(200); chk("m_clamp", int'(bus.q), 9);
    bus.sel = 1'b0; cnt = 0;
    do begin tick(); cnt++; end while (bus.q != 8'd6 && cnt < 20);
    chk("m_rewrap_match", int'(bus.cmp_match), 1);
    bus.ena = 1'b0; load(6); chk("m_load_match", int'(bus.cmp_match), 1);
    tick(); chk("m_hold_nomatch", int'(bus.cmp_match), 0);

    // saturate
    bus.mode = 2'b10; bus.top = 8'd100; bus.step = 8'd30; bus.ena = 1'b1;
    load(50);
    tick_q("s0", 80, 0); tick_q("s1", 100, 1); tick_q("s2", 100, 0); tick_q("s3", 100, 0);
    load(20); bus.sel = 1'b1; tick_q("s4", 0, 1);

    // one-shot
    bus.mode = 2'b11; bus.top = 8'd10; bus.step = 8'd4; bus.sel = 1'b0;
    load(0);
    tick_q("o0", 4, 0); tick_q("o1", 8, 0); tick_q("o2", 10, 1);
    chk("o2_done", int'(bus.done), 1);
    tick_q("o3", 10, 0); chk("o3_done", int'(bus.done), 1);
    load(0); chk("o4_done", int'(bus.done), 0);
    tick_q("o5", 4, 0);

    // reset mid-count, and over a load
    srst = 1'b1; tick_q("r0", 5, 0); chk("r0_done", int'(bus.done), 0);
    bus.sload = 1'b1; bus.d_load = 8'd77; tick(); chk("r1_q", int'(bus.q), 5);
    bus.sload = 1'b0; srst = 1'b0;

`ifdef COUNTER_MOD_CMP_CAPTURE_EN
    bus.mode = 2'b01; bus.top = 8'd9; bus.step = 8'd3; bus.cmp = 8'd6;
    load(3); bus.cap = 1'b1; tick(); bus.cap = 1'b0;
    chk("cap_q", int'(bus.cap_q), 3);
    chk("cap_cur", int'(bus.q), 6);
`endif

    // randomized segments
    for (int seg = 0; seg < 40; seg++) begin
      tp = $urandom_range(5, 254);
      bus.mode = 2'($urandom_range(0, 3));
      bus.top  = W'(tp);
      bus.cmp  = W'($urandom_range(0, tp));
      load($urandom_range(0, 255));
      for (int i = 0; i < 25; i++) begin
        srst      = ($urandom_range(0, 99) < 2);
        bus.sload = ($urandom_range(0, 99) < 6);
        bus.d_load = W'($urandom_range(0, 255));
        bus.ena   = ($urandom_range(0, 99) < 80);
        bus.sel   = 1'($urandom_range(0, 1));
        bus.step  = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom_range(1, tp + 1));
        if ($urandom_range(0, 3) == 0) bus.cmp = bus.q;
`ifdef COUNTER_MOD_CMP_CAPTURE_EN
        bus.cap = 1'($urandom_range(0, 1));
`endif
        tick();
      end
      srst = 1'b0; bus.sload = 1'b0;
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
